dcache_fill_fsm: RTL

Miss-fill controller for the data cache in the MEM stage of the 16-bit pipeline. It receives a miss indication and address from the MEM stage and raises a stall to the pipeline, which freezes the pipeline registers through their write enables. It then issues one read per word of the missing block to multi-cycle main memory. Returned words are steered into the cache data array, and the tag is written when the last word lands.

---
 rtl/dcache_fill_fsm.sv | 79 +++++++
 1 files changed

// File: rtl/dcache_fill_fsm.sv
// Data-cache miss-fill controller: stalls the pipeline on a miss, streams one read per block word,
// steers returned words into the data array and writes the tag with the last word.
module dcache_fill_fsm #(
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic [15:0] memory_data,
    output logic        fsm_busy,
    output logic        memory_read,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [2:0]  cache_word_offset,
    output logic [15:0] fill_data,
    output logic        write_tag_array
);

    localparam int          OFF_BITS  = $clog2(2 * BLOCK_WORDS);
    localparam logic [15:0] BASE_MASK = ~16'((1 << OFF_BITS) - 1);
    localparam logic [3:0]  ISSUE_END = 4'(BLOCK_WORDS);
    localparam logic [2:0]  RECV_LAST = 3'(BLOCK_WORDS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]  state;
    logic [15:0] base;
    logic [3:0]  issue_cnt;
    logic [2:0]  recv_cnt;

    logic in_fill;
    logic issuing;
    logic word_arrives;
    logic last_word;

    assign in_fill      = (state == FILL);
    assign issuing      = in_fill && (issue_cnt < ISSUE_END);
    assign word_arrives = in_fill && memory_data_valid;
    assign last_word    = word_arrives && (recv_cnt == RECV_LAST);

    // Requests and returns are decoupled: issue runs back to back, receive just counts valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= 16'h0000;
            issue_cnt <= 4'd0;
            recv_cnt  <= 3'd0;
        end else if (state == IDLE) begin
            if (miss_detected) begin
                base      <= miss_address & BASE_MASK;
                issue_cnt <= 4'd0;
                recv_cnt  <= 3'd0;
                state     <= FILL;
            end
        end else begin
            if (issuing) begin
                issue_cnt <= issue_cnt + 4'd1;
            end
            if (word_arrives) begin
                recv_cnt <= recv_cnt + 3'd1;
            end
            if (last_word) begin
                state <= IDLE;
            end
        end
    end

    assign fsm_busy          = in_fill || miss_detected;
    assign memory_read       = issuing;
    assign memory_address    = base + {11'd0, issue_cnt, 1'b0};
    assign write_data_array  = word_arrives;
    assign cache_word_offset = recv_cnt;
    assign fill_data         = memory_data;
    assign write_tag_array   = last_word;

endmodule
